// File: rtl/uart_tx_unit.sv
// uart_tx_unit: UART transmit engine, the counterpart of the RxUnit receive path.
// It builds the 11-bit frame {stop, parity, data[7:0], start} and shifts it out
// LSB-first. The parity_type and baud_rate encodings match the receiver.
//
// Ports:
//   clock        system clock; all state updates on the rising edge
//   reset_n      asynchronous, active-low reset
//   tx_enable    gates the start of new frames; a frame already running is not aborted
//   send         transmit request, level-sampled in IDLE only
//   data_in      byte to transmit
//   parity_type  00/11 none (slot sent as 1), 01 odd, 10 even
//   baud_rate    00 2400, 01 4800, 10 9600, 11 19200 baud
//   data_tx      serial line, idles high
//   active_flag  high while a frame is on the line
//   done_flag    one-cycle pulse in the first idle cycle after the stop bit
//   baud_clk_T   one-cycle strobe on the last cycle of each bit
//   Sent_Frame   latched frame: [0] start, [8:1] data, [9] parity, [10] stop
module uart_tx_unit #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        tx_enable,
  input  logic        send,
  input  logic [7:0]  data_in,
  input  logic [1:0]  parity_type,
  input  logic [1:0]  baud_rate,
  output logic        data_tx,
  output logic        active_flag,
  output logic        done_flag,
  output logic        baud_clk_T,
  output logic [10:0] Sent_Frame
);

  // Rounded bit periods in clock cycles
  localparam int unsigned DIV_2400  = (CLK_FREQ + 1200) / 2400;
  localparam int unsigned DIV_4800  = (CLK_FREQ + 2400) / 4800;
  localparam int unsigned DIV_9600  = (CLK_FREQ + 4800) / 9600;
  localparam int unsigned DIV_19200 = (CLK_FREQ + 9600) / 19200;
  localparam int unsigned DIV_W     = $clog2(DIV_2400 + 1);
  localparam logic [3:0]  LAST_BIT  = 4'd10;

  typedef enum logic {
    IDLE,
    TX
  } state_t;

  state_t            state, state_next;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_sel;
  logic [DIV_W-1:0]  baud_cnt;
  logic [3:0]        bit_idx;
  logic [10:0]       frame_q;
  logic [10:0]       frame_next;
  logic              parity_bit;
  logic              done_q;
  logic              start_frame;
  logic              bit_end;

  assign start_frame = (state == IDLE) && send && tx_enable;
  assign bit_end     = (state == TX) && (baud_cnt == div_q - DIV_W'(1));

  always_comb begin
    div_sel = DIV_W'(DIV_2400);
    case (baud_rate)
      2'b00:   div_sel = DIV_W'(DIV_2400);
      2'b01:   div_sel = DIV_W'(DIV_4800);
      2'b10:   div_sel = DIV_W'(DIV_9600);
      default: div_sel = DIV_W'(DIV_19200);
    endcase
  end

  always_comb begin
    parity_bit = 1'b1;
    case (parity_type)
      2'b01:   parity_bit = ~^data_in;
      2'b10:   parity_bit = ^data_in;
      default: parity_bit = 1'b1;
    endcase
    frame_next = {1'b1, parity_bit, data_in, 1'b0};
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_frame) begin
          state_next = TX;
        end
      end
      TX: begin
        if (bit_end && (bit_idx == LAST_BIT)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame latch, bit timing and completion pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_q  <= '0;
      div_q    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_frame) begin
            frame_q  <= frame_next;
            div_q    <= div_sel;
            baud_cnt <= '0;
            bit_idx  <= '0;
          end
        end
        TX: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              done_q <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state so reset forces them without a clock
  always_comb begin
    data_tx     = 1'b1;
    active_flag = 1'b0;
    if (state == TX) begin
      data_tx     = frame_q[bit_idx];
      active_flag = 1'b1;
    end
  end

  assign baud_clk_T = bit_end;
  assign done_flag  = done_q;
  assign Sent_Frame = frame_q;

endmodule

// File: doc/uart_tx_unit.md
Name: uart_tx_unit

Overview:
UART transmit engine; the transmit-side counterpart of the RxUnit receive path.
- Builds the 11-bit frame {stop, parity, data[7:0], start} from a byte and serialises it LSB-first on data_tx.
- Uses the same parity_type and baud_rate encodings as the receiver, so a Tx/Rx pair configured identically interoperate.
- Integrates its own 1x baud divider, frame builder and shift FSM, with a send/active/done handshake toward the host logic.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz. Bit period DIV = (CLK_FREQ + rate/2) / rate, using integer arithmetic.

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
tx_enable  input  1  gate for starting new frames; does not abort a frame in progress
send  input  1  request to transmit data_in; level-sampled in IDLE only
data_in  input  8  byte to transmit
parity_type  input  2  00 = none (slot sent as 1), 01 = odd, 10 = even, 11 = none (slot sent as 1)
baud_rate  input  2  00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200 baud
data_tx  output  1  serial line; idles high
active_flag  output  1  high while a frame is on the line
done_flag  output  1  one-cycle pulse after the stop bit completes
baud_clk_T  output  1  one-cycle strobe at each bit boundary during a frame
Sent_Frame  output  11  latched frame: [0] start = 0, [8:1] data, [9] parity, [10] stop = 1

Behaviour:
Reset (asynchronous, reset_n = 0), all outputs forced immediately:
- data_tx = 1, active_flag = 0, done_flag = 0, baud_clk_T = 0, Sent_Frame = 0.
- FSM goes to IDLE; baud counter and bit index cleared.

FSM states: IDLE, TX.

IDLE:
- data_tx = 1.
- If send = 1 and tx_enable = 1 at a rising edge, that edge:
  - latches the frame into Sent_Frame;
  - latches DIV from baud_rate;
  - clears the baud counter and sets bit index = 0;
  - moves the FSM to TX.
- On the next cycle data_tx = Sent_Frame[0] and active_flag = 1.

TX:
- data_tx = Sent_Frame[bit index]. Each bit is held for exactly DIV clock cycles, so a frame lasts 11*DIV cycles.
- On the last cycle of each bit, baud_clk_T = 1 for one cycle and the bit index increments.
- After bit 10 (stop) completes:
  - FSM returns to IDLE and active_flag = 0;
  - done_flag = 1 in that first IDLE cycle.

Parity computation:
- Odd: parity = ~^data_in (total ones in data plus parity is odd).
- Even: parity = ^data_in.
- None (00 or 11): parity = 1.

Boundary conditions:
- send during TX is ignored; there is no queueing.
- send held continuously: the next frame is latched at the edge ending the done_flag cycle. Consecutive frames are therefore separated by exactly 1 idle-high cycle.
- send = 1 with tx_enable = 0: no frame starts.
- tx_enable dropped mid-frame: the current frame completes normally.
- baud_rate, parity_type or data_in changing mid-frame: no effect, because all three are latched at frame start.
- Reset mid-frame: line returns high immediately, no done_flag is produced, and the frame is lost.

Divisors at the default CLK_FREQ: 20833, 10417, 5208, 2604. With CLK_FREQ = 192000 (simulation): 80, 40, 20, 10.

Test Plan:
1. CLK_FREQ = 192000, baud_rate = 11, parity_type = 10, data_in = 8'hA5, one-cycle send -> Sent_Frame = 11'b1_0_10100101_0; data_tx sequence 0,1,0,1,0,0,1,0,1,0,1 with each bit held 10 cycles; done_flag pulses exactly 110 cycles after the first start-bit cycle.
2. data_in = 8'h07 with parity_type 01, then 10, then 00 -> parity bit 0, then 1, then 1.
3. baud_rate 00 vs 10 at CLK_FREQ = 192000 -> start bit low for 80 cycles vs 20 cycles; baud_clk_T strobes at the same interval (11 strobes per frame).
4. send held high for 3 frames -> exactly 1 high idle cycle between each stop bit and the next start bit; 3 done_flag pulses.
5. send pulsed mid-frame, and data_in/baud_rate changed mid-frame -> current frame is unchanged and no extra frame is sent; send with tx_enable = 0 -> data_tx stays 1.
6. reset_n asserted during data bit 4 -> data_tx = 1 and active_flag = 0 asynchronously, with no done_flag; a new send after release transmits a clean full frame.
